// File: rtl/rd_resp_mux_pkg.sv
// Shared types and helpers for the registered read-response multiplexer.
package rd_resp_mux_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  // Width helper that never returns zero, so single-entry vectors still get a 1-bit field.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rd_resp_mux_onehot_enc.sv
// One-hot classifier and encoder: reports exactly-one / all-zero and the index of the set bit.
module onehot_enc
  import rd_resp_mux_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0]               vec,
  output logic [clog2_min1(W)-1:0]   idx,
  output logic                       one,
  output logic                       none
);

  localparam int IW = clog2_min1(W);

  always_comb begin
    idx = '0;
    for (int i = 0; i < W; i++) begin
      if (vec[i]) idx = IW'(i);
    end
  end

  assign none = (vec == '0);
  assign one  = !none && ((vec & (vec - W'(1))) == '0);

endmodule

// File: rtl/rd_resp_mux.sv
// Transaction-aware read-response router: one outstanding read, timeout and decode-error reporting.
//  state | meaning
//  IDLE  | ready for a request, nothing outstanding
//  WAIT  | request forwarded, waiting on the selected slave (timer running)
//  RESP  | response held on rd/rerr with rvld=1 until the master takes it
module rd_resp_mux
  import rd_resp_mux_pkg::*;
#(
  parameter int              SLV_C    = 4,
  parameter int              DW       = 32,
  parameter int              TIMEOUT  = 16,
  parameter logic [DW-1:0]   ERR_DATA = DW'(ERR_DATA_DEF),
  parameter int              ERR_CW   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_vld,
  input  logic [SLV_C-1:0]             req_sel,
  output logic                         req_rdy,
  output logic [SLV_C-1:0]             act_sel,
  input  logic [SLV_C-1:0]             rvld_s,
  input  logic [SLV_C-1:0][DW-1:0]     rd_s,
  output logic [DW-1:0]                rd,
  output logic                         rvld,
  output logic                         rerr,
  input  logic                         rrdy,
  output logic [ERR_CW-1:0]            err_cnt
);

  localparam int IW = clog2_min1(SLV_C);
  localparam int TW = clog2_min1(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

  state_t           state;
  logic [TW-1:0]    timer;
  logic [SLV_C-1:0] enc_vec;
  logic [IW-1:0]    enc_idx;
  logic             enc_one;
  logic             enc_none;
  logic             dec_ok;
  logic             sel_rsp;
  logic             err_full;

  // The encoder checks the incoming select while idle and indexes the latched select otherwise.
  assign enc_vec = (state == IDLE) ? req_sel : act_sel;

  onehot_enc #(.W(SLV_C)) u_enc (
    .vec  (enc_vec),
    .idx  (enc_idx),
    .one  (enc_one),
    .none (enc_none)
  );

  assign dec_ok   = enc_one && !enc_none;
  assign sel_rsp  = |(rvld_s & act_sel);
  assign err_full = (err_cnt == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      req_rdy <= 1'b1;
      act_sel <= '0;
      rd      <= '0;
      rvld    <= 1'b0;
      rerr    <= 1'b0;
      err_cnt <= '0;
      timer   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_vld) begin
            req_rdy <= 1'b0;
            if (dec_ok) begin
              act_sel <= req_sel;
              timer   <= '0;
              state   <= WAIT;
            end else begin
              rd    <= ERR_DATA;
              rerr  <= 1'b1;
              rvld  <= 1'b1;
              state <= RESP;
              if (!err_full) err_cnt <= err_cnt + 1'b1;
            end
          end
        end
        WAIT: begin
          // A response arriving on the last timer cycle still wins over the timeout.
          if (sel_rsp) begin
            rd    <= rd_s[enc_idx];
            rerr  <= 1'b0;
            rvld  <= 1'b1;
            state <= RESP;
          end else begin
            timer <= timer + 1'b1;
            if ((TIMEOUT != 0) && (timer == TO_LAST)) begin
              rd    <= ERR_DATA;
              rerr  <= 1'b1;
              rvld  <= 1'b1;
              state <= RESP;
              if (!err_full) err_cnt <= err_cnt + 1'b1;
            end
          end
        end
        RESP: begin
          if (rrdy) begin
            rvld    <= 1'b0;
            act_sel <= '0;
            req_rdy <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          req_rdy <= 1'b1;
          rvld    <= 1'b0;
          act_sel <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rd_resp_mux.sv
// Randomized and directed bench for rd_resp_mux against a transaction-level reference model.
module tb_rd_resp_mux;

  localparam int SLV_C = 4;
  localparam int DW = 32;
  localparam int TIMEOUT = 16;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     req_vld;
  logic [SLV_C-1:0]         req_sel;
  logic [SLV_C-1:0]         rvld_s;
  logic [SLV_C-1:0][DW-1:0] rd_s;
  logic                     rrdy;

  logic                     req_rdy, rvld, rerr;
  logic [SLV_C-1:0]         act_sel;
  logic [DW-1:0]            rd;
  logic [7:0]               err_cnt;

  logic                     req_rdy2, rvld2, rerr2;
  logic [SLV_C-1:0]         act_sel2;
  logic [DW-1:0]            rd2;
  logic [1:0]               err_cnt2;

  int total = 0;
  int bad = 0;

  rd_resp_mux #(.SLV_C(SLV_C), .DW(DW), .TIMEOUT(TIMEOUT), .ERR_CW(8)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_sel(req_sel), .req_rdy(req_rdy),
    .act_sel(act_sel), .rvld_s(rvld_s), .rd_s(rd_s), .rd(rd), .rvld(rvld),
    .rerr(rerr), .rrdy(rrdy), .err_cnt(err_cnt)
  );

  rd_resp_mux #(.SLV_C(SLV_C), .DW(DW), .TIMEOUT(TIMEOUT), .ERR_CW(2)) dut2 (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_sel(req_sel), .req_rdy(req_rdy2),
    .act_sel(act_sel2), .rvld_s(rvld_s), .rd_s(rd_s), .rd(rd2), .rvld(rvld2),
    .rerr(rerr2), .rrdy(rrdy), .err_cnt(err_cnt2)
  );

  always #5 clk = ~clk;

  // Reference model: one outstanding transaction described by flags and counters.
  bit          m_wait, m_resp, m_err;
  int          m_slave, m_waited, m_errs;
  logic [3:0]  m_act;
  logic [31:0] m_rd;

  task automatic model_clear();
    m_wait = 0; m_resp = 0; m_err = 0;
    m_slave = 0; m_waited = 0; m_errs = 0;
    m_act = '0; m_rd = '0;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      model_clear();
    end else if (m_resp) begin
      if (rrdy) begin
        m_resp = 0;
        m_act = '0;
      end
    end else if (m_wait) begin
      if (rvld_s[m_slave]) begin
        m_wait = 0; m_resp = 1; m_rd = rd_s[m_slave]; m_err = 0;
      end else begin
        m_waited++;
        if (TIMEOUT != 0 && m_waited == TIMEOUT) begin
          m_wait = 0; m_resp = 1; m_rd = ERRD; m_err = 1; m_errs++;
        end
      end
    end else if (req_vld) begin
      if ($countones(req_sel) == 1) begin
        m_wait = 1; m_waited = 0; m_act = req_sel;
        for (int i = 0; i < SLV_C; i++) if (req_sel[i]) m_slave = i;
      end else begin
        m_resp = 1; m_rd = ERRD; m_err = 1; m_errs++;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      check("req_rdy", req_rdy, !(m_wait || m_resp));
      check("act_sel", act_sel, m_act);
      check("rvld", rvld, m_resp);
      check("rd", rd, m_rd);
      if (m_resp) check("rerr", rerr, m_err);
      check("err_cnt", err_cnt, sat(m_errs, 255));
      check("req_rdy2", req_rdy2, !(m_wait || m_resp));
      check("act_sel2", act_sel2, m_act);
      check("rvld2", rvld2, m_resp);
      check("rd2", rd2, m_rd);
      if (m_resp) check("rerr2", rerr2, m_err);
      check("err_cnt2_sat", err_cnt2, sat(m_errs, 3));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; req_vld = 0; req_sel = '0; rvld_s = '0; rd_s = '0; rrdy = 1'b1;
    model_clear();
    tick(); tick();
    check("rst_req_rdy", req_rdy, 1'b1);
    check("rst_rvld", rvld, 1'b0);
    check("rst_act_sel", act_sel, 4'b0000);
    check("rst_rd", rd, 32'h0);
    check("rst_err_cnt", err_cnt, 8'd0);
    rst = 1'b0;
    tick();

    // basic read from slave 2, response two cycles after accept
    req_vld = 1; req_sel = 4'b0100;
    tick();
    req_vld = 0; req_sel = '0;
    check("t1_act_sel", act_sel, 4'b0100);
    check("t1_req_rdy", req_rdy, 1'b0);
    tick();
    check("t1_rvld_early", rvld, 1'b0);
    rvld_s = 4'b0100; rd_s[2] = 32'h1234_5678;
    tick();
    rvld_s = '0;
    check("t1_rvld", rvld, 1'b1);
    check("t1_rd", rd, 32'h1234_5678);
    check("t1_rerr", rerr, 1'b0);
    check("t1_model_rd", m_rd, 32'h1234_5678);
    tick();
    check("t1_idle_rdy", req_rdy, 1'b1);
    check("t1_idle_rvld", rvld, 1'b0);

    // decode errors: zero and multi-hot
    req_vld = 1; req_sel = 4'b0000;
    tick();
    req_sel = 4'b0110;
    check("t2_rvld_zero", rvld, 1'b1);
    check("t2_rd_zero", rd, ERRD);
    check("t2_rerr_zero", rerr, 1'b1);
    tick();
    check("t2_between", rvld, 1'b0);
    tick();
    req_vld = 0; req_sel = '0;
    check("t2_rvld_multi", rvld, 1'b1);
    check("t2_rerr_multi", rerr, 1'b1);
    check("t2_act_sel", act_sel, 4'b0000);
    check("t2_err_cnt", err_cnt, 8'd2);
    check("t2_model_errs", m_errs, 2);
    tick();

    // timeout on slave 0, then a late response is ignored
    rrdy = 0;
    req_vld = 1; req_sel = 4'b0001;
    tick();
    req_vld = 0; req_sel = '0;
    n = 1;
    while (!rvld && n < 40) begin
      tick();
      n++;
    end
    check("t3_timeout_lat", n, 17);
    check("t3_rerr", rerr, 1'b1);
    check("t3_rd", rd, ERRD);
    rrdy = 1;
    tick();
    rvld_s = 4'b0001; rd_s[0] = 32'h5555_AAAA;
    repeat (3) tick();
    check("t3_late_rvld", rvld, 1'b0);
    check("t3_late_rd", rd, ERRD);
    check("t3_late_rdy", req_rdy, 1'b1);
    rvld_s = '0;

    // response on the timeout cycle wins; unselected slave valid ignored
    req_vld = 1; req_sel = 4'b0001; rvld_s = 4'b1000; rd_s[3] = 32'hBAD0_0003;
    tick();
    req_vld = 0; req_sel = '0;
    repeat (15) tick();
    check("t4_no_early", rvld, 1'b0);
    rvld_s = 4'b1001; rd_s[0] = 32'hCAFE_0001;
    tick();
    rvld_s = '0;
    check("t4_rvld", rvld, 1'b1);
    check("t4_rerr", rerr, 1'b0);
    check("t4_rd", rd, 32'hCAFE_0001);
    tick();

    // backpressure
    rrdy = 0;
    req_vld = 1; req_sel = 4'b0010;
    tick();
    req_vld = 0; req_sel = '0;
    rvld_s = 4'b0010; rd_s[1] = 32'hA5A5_0101;
    tick();
    req_vld = 1; req_sel = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      rd_s[1] = $urandom; rvld_s = 4'($urandom);
      tick();
      check("t5_rvld", rvld, 1'b1);
      check("t5_rd", rd, 32'hA5A5_0101);
      check("t5_req_rdy", req_rdy, 1'b0);
    end
    rvld_s = '0;
    rrdy = 1;
    tick();
    check("t5_hs_rvld", rvld, 1'b0);
    check("t5_hs_rdy", req_rdy, 1'b1);
    check("t5_hs_act", act_sel, 4'b0000);
    tick();
    req_vld = 0; req_sel = '0;
    check("t5_accept", act_sel, 4'b0001);

    // asynchronous reset in WAIT, then in RESP
    tick();
    rst = 1;
    #1;
    check("t6_wait_act", act_sel, 4'b0000);
    check("t6_wait_rdy", req_rdy, 1'b1);
    tick();
    rst = 0;
    rrdy = 0;
    req_vld = 1; req_sel = 4'b0000;
    tick();
    req_vld = 0;
    check("t6_resp_rvld", rvld, 1'b1);
    rst = 1;
    #1;
    check("t6_rst_rvld", rvld, 1'b0);
    check("t6_rst_cnt", err_cnt, 8'd0);
    tick();
    rst = 0;
    rrdy = 1;

    // saturation of the narrow error counter
    req_vld = 1; req_sel = 4'b0011;
    repeat (10) tick();
    req_vld = 0; req_sel = '0;
    check("t7_cnt8", err_cnt, 8'd5);
    check("t7_cnt2", err_cnt2, 2'd3);
    check("t7_model_errs", m_errs, 5);
    tick();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      req_vld = ($urandom_range(0, 3) == 0);
      req_sel = ($urandom_range(0, 4) == 0) ? 4'($urandom) : (4'b0001 << $urandom_range(0, 3));
      for (int s = 0; s < SLV_C; s++) begin
        rvld_s[s] = ($urandom_range(0, 5) == 0);
        rd_s[s] = $urandom;
      end
      rrdy = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
